// File: rtl/count_seq_checker_pkg.sv
// Shared types and default parameters for the counter-stream sequence checker.
package count_seq_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam int DEF_BW         = 3;
  localparam int DEF_LOCK_CNT   = 2;
  localparam int DEF_UNLOCK_CNT = 2;
  localparam int DEF_ERR_W      = 8;

  // Bits needed to hold a run length of 0..n.
  function automatic int run_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating event counter with synchronous clear; a clear that coincides
// with an increment leaves the count at one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= inc_i ? W'(1) : '0;
    end else if (inc_i && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/count_seq_checker.sv
// Lock/track checker for a free-running +1 counter stream.
// Optional COUNT_SEQ_CHECKER_DOWN_EN adds dir_i to also accept -1 streams.
module count_seq_checker
  import count_seq_checker_pkg::*;
#(
  parameter int BW         = DEF_BW,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
  parameter int ERR_W      = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_i,
`ifdef COUNT_SEQ_CHECKER_DOWN_EN
  input  logic             dir_i,
`endif
  input  logic [BW-1:0]    count_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [BW-1:0]    expected_o
);

  localparam int GW = run_w(LOCK_CNT);
  localparam int BRW = run_w(UNLOCK_CNT);
  localparam logic [GW-1:0]  GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BRW-1:0] BAD_LAST  = BRW'(UNLOCK_CNT - 1);
  localparam logic [BW-1:0]  ONE       = BW'(1);

  state_t          r_state;
  logic [BW-1:0]   r_prev;
  logic [BW-1:0]   r_expected;
  logic [GW-1:0]   r_good_run;
  logic [BRW-1:0]  r_bad_run;
  logic            r_locked;
  logic            r_err;

  logic            w_dir;
  logic [BW-1:0]   w_want;
  logic            w_match;
  logic            w_err_evt;

`ifdef COUNT_SEQ_CHECKER_DOWN_EN
  assign w_dir = dir_i;
`else
  assign w_dir = 1'b0;
`endif

  // Modular +/-1: the BW-bit result drops the carry/borrow, so wrap is good.
  assign w_want    = w_dir ? (r_prev - ONE) : (r_prev + ONE);
  assign w_match   = (count_i == w_want);
  assign w_err_evt = sample_i && (r_state == ST_LOCKED) && !w_match;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_prev     <= '0;
      r_expected <= '0;
      r_good_run <= '0;
      r_bad_run  <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (sample_i) begin
        // Always resync to the observed value so one skip costs one error.
        r_prev     <= count_i;
        r_expected <= w_dir ? (count_i - ONE) : (count_i + ONE);
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_ACQUIRE;
            r_good_run <= '0;
          end
          ST_ACQUIRE: begin
            if (w_match) begin
              if (r_good_run == GOOD_LAST) begin
                r_state   <= ST_LOCKED;
                r_locked  <= 1'b1;
                r_bad_run <= '0;
              end else begin
                r_good_run <= r_good_run + 1'b1;
              end
            end else begin
              r_good_run <= '0;
            end
          end
          ST_LOCKED: begin
            if (w_match) begin
              r_bad_run <= '0;
            end else begin
              r_err <= 1'b1;
              if (r_bad_run == BAD_LAST) begin
                r_state    <= ST_ACQUIRE;
                r_locked   <= 1'b0;
                r_good_run <= '0;
              end else begin
                r_bad_run <= r_bad_run + 1'b1;
              end
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clear_i),
    .inc_i (w_err_evt),
    .cnt_o (err_cnt_o)
  );

  assign locked_o   = r_locked;
  assign err_o      = r_err;
  assign expected_o = r_expected;

endmodule

// File: tb/tb_count_seq_checker.sv
// Self-checking bench: directed scenarios plus randomized stream against a
// behavioural model; honours COUNT_SEQ_CHECKER_DOWN_EN when defined.
module tb_count_seq_checker;

  localparam int BW  = 3;
  localparam int MOD = 1 << BW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample = 1'b0;
  logic       clear = 1'b0;
  logic       dir = 1'b0;
  logic [2:0] count = '0;

  logic       locked, err, locked2, err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic [2:0] expected, expected2;

  int total = 0;
  int bad = 0;

  // Behavioural model state
  bit m_started, m_locked, m_err;
  int m_prev, m_good, m_bad, m_cnt, m_cnt_sat, m_exp;

  always #5 clk = ~clk;

  count_seq_checker dut (
    .clk(clk), .rst_n(rst_n), .sample_i(sample),
`ifdef COUNT_SEQ_CHECKER_DOWN_EN
    .dir_i(dir),
`endif
    .count_i(count), .clear_i(clear),
    .locked_o(locked), .err_o(err), .err_cnt_o(err_cnt), .expected_o(expected)
  );

  count_seq_checker #(.ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sample_i(sample),
`ifdef COUNT_SEQ_CHECKER_DOWN_EN
    .dir_i(dir),
`endif
    .count_i(count), .clear_i(clear),
    .locked_o(locked2), .err_o(err2), .err_cnt_o(err_cnt2), .expected_o(expected2)
  );

  task automatic drive(input bit r, input bit s, input int v, input bit c, input bit d);
    int want;
    bit good;
    rst_n = r; sample = s; count = 3'(v); clear = c; dir = d;
    @(posedge clk);
    if (!r) begin
      m_started = 0; m_locked = 0; m_err = 0; m_prev = 0; m_good = 0;
      m_bad = 0; m_cnt = 0; m_cnt_sat = 0; m_exp = 0;
    end else begin
      m_err = 0;
      if (c) begin m_cnt = 0; m_cnt_sat = 0; end
      if (s) begin
        want = d ? (m_prev + MOD - 1) % MOD : (m_prev + 1) % MOD;
        good = ((v % MOD) == want);
        if (!m_started) begin
          m_started = 1; m_good = 0;
        end else if (!m_locked) begin
          if (good) begin
            m_good++;
            if (m_good >= 2) begin m_locked = 1; m_bad = 0; end
          end else m_good = 0;
        end else begin
          if (good) m_bad = 0;
          else begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt_sat < 3) m_cnt_sat++;
            m_bad++;
            if (m_bad >= 2) begin m_locked = 0; m_good = 0; end
          end
        end
        m_prev = v % MOD;
        m_exp = d ? (m_prev + MOD - 1) % MOD : (m_prev + 1) % MOD;
      end
    end
    #1;
    $display("txn rst_n=%0b smp=%0b cnt=%0d clr=%0b dir=%0b -> locked=%0b err=%0b err_cnt=%0d exp=%0d sat_cnt=%0d",
             r, s, v, c, d, locked, err, err_cnt, expected, err_cnt2);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive(0, 1, 5, 1, 0);
    total++;
    if ({locked, err, err_cnt, expected, locked2, err2, err_cnt2, expected2} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs got locked=%0b err=%0b cnt=%0d exp=%0d want all 0", locked, err, err_cnt, expected);
    end
  endtask

  task automatic test_acquire();
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL acq_early_lock got=%0b want=0", locked); end
    drive(1, 1, 2, 0, 0);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL acq_locked got=%0b want=1", locked); end
    total++;
    if (expected !== 3'd3) begin bad++; $display("FAIL acq_expected got=%0d want=3", expected); end
  endtask

  task automatic test_wrap();
    int errs = 0;
    int seq[7] = '{3, 4, 5, 6, 7, 0, 1};
    foreach (seq[i]) begin
      drive(1, 1, seq[i], 0, 0);
      if (err) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL wrap_err_pulses got=%0d want=0", errs); end
    total++;
    if (err_cnt !== 8'd0 || locked !== 1'b1) begin
      bad++; $display("FAIL wrap_state got cnt=%0d locked=%0b want cnt=0 locked=1", err_cnt, locked);
    end
    total++;
    if (expected !== 3'd2) begin bad++; $display("FAIL wrap_expected got=%0d want=2", expected); end
  endtask

  task automatic test_single_skip();
    int errs = 0;
    int seq[3] = '{5, 7, 0};
    for (int v = 2; v <= 4; v++) drive(1, 1, v, 0, 0);
    foreach (seq[i]) begin
      drive(1, 1, seq[i], 0, 0);
      total++;
      if (err !== (i == 1)) begin bad++; $display("FAIL skip_err_%0d got=%0b want=%0b", i, err, (i == 1)); end
      if (err) errs++;
    end
    total++;
    if (err_cnt !== 8'd1 || locked !== 1'b1 || expected !== 3'd1) begin
      bad++; $display("FAIL skip_state got cnt=%0d locked=%0b exp=%0d want 1/1/1", err_cnt, locked, expected);
    end
  endtask

  task automatic test_lock_loss();
    int seq[3] = '{3, 5, 1};
    bit want_err[3] = '{0, 1, 1};
    drive(1, 0, 0, 1, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 2, 0, 0);
    foreach (seq[i]) begin
      drive(1, 1, seq[i], 0, 0);
      total++;
      if (err !== want_err[i]) begin bad++; $display("FAIL loss_err_%0d got=%0b want=%0b", i, err, want_err[i]); end
    end
    total++;
    if (err_cnt !== 8'd2 || locked !== 1'b0) begin
      bad++; $display("FAIL loss_state got cnt=%0d locked=%0b want cnt=2 locked=0", err_cnt, locked);
    end
    drive(1, 1, 2, 0, 0);
    total++;
    if (err !== 1'b0 || locked !== 1'b0) begin
      bad++; $display("FAIL relock_mid got err=%0b locked=%0b want 0/0", err, locked);
    end
    drive(1, 1, 3, 0, 0);
    total++;
    if (err !== 1'b0 || locked !== 1'b1) begin
      bad++; $display("FAIL relock got err=%0b locked=%0b want 0/1", err, locked);
    end
  endtask

  task automatic test_saturation();
    int seq[10] = '{5, 6, 0, 1, 3, 4, 6, 7, 1, 2};
    drive(1, 0, 0, 1, 0);
    foreach (seq[i]) begin
      drive(1, 1, seq[i], 0, 0);
      total++;
      if (err2 !== (i % 2 == 0)) begin bad++; $display("FAIL sat_err_%0d got=%0b want=%0b", i, err2, (i % 2 == 0)); end
    end
    total++;
    if (err_cnt2 !== 2'd3 || err_cnt !== 8'd5 || locked2 !== 1'b1) begin
      bad++; $display("FAIL sat_count got sat=%0d wide=%0d locked=%0b want 3/5/1", err_cnt2, err_cnt, locked2);
    end
    drive(1, 0, 0, 1, 0);
    total++;
    if (err_cnt2 !== 2'd0 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL clear_alone got sat=%0d wide=%0d want 0/0", err_cnt2, err_cnt);
    end
    drive(1, 1, 4, 1, 0);
    total++;
    if (err_cnt2 !== 2'd1 || err2 !== 1'b1) begin
      bad++; $display("FAIL clear_with_err got cnt=%0d err=%0b want 1/1", err_cnt2, err2);
    end
    drive(1, 1, 5, 0, 0);
  endtask

  task automatic test_gap();
    int errs = 0;
    drive(1, 1, 6, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, i, 0, 0);
      if (err) errs++;
    end
    drive(1, 1, 7, 0, 0);
    if (err) errs++;
    total++;
    if (errs != 0 || locked !== 1'b1 || expected !== 3'd0) begin
      bad++; $display("FAIL gap got errs=%0d locked=%0b exp=%0d want 0/1/0", errs, locked, expected);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 3, 0, 0);
    total++;
    if (err_cnt === 8'd0 || locked !== 1'b1) begin
      bad++; $display("FAIL pre_reset got cnt=%0d locked=%0b want nonzero/1", err_cnt, locked);
    end
    drive(0, 0, 0, 0, 0);
    total++;
    if (locked !== 1'b0 || err_cnt !== 8'd0 || expected !== 3'd0) begin
      bad++; $display("FAIL reset_mid got locked=%0b cnt=%0d exp=%0d want 0/0/0", locked, err_cnt, expected);
    end
  endtask

`ifdef COUNT_SEQ_CHECKER_DOWN_EN
  task automatic test_down();
    int errs = 0;
    drive(0, 0, 0, 0, 1);
    drive(1, 1, 1, 0, 1);
    drive(1, 1, 0, 0, 1);
    if (err) errs++;
    drive(1, 1, 7, 0, 1);
    if (err) errs++;
    total++;
    if (errs != 0 || locked !== 1'b1 || expected !== 3'd6) begin
      bad++; $display("FAIL down_lock got errs=%0d locked=%0b exp=%0d want 0/1/6", errs, locked, expected);
    end
  endtask
`endif

  task automatic test_random();
    bit d = 0;
    bit r, s, c;
    int v;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
`ifdef COUNT_SEQ_CHECKER_DOWN_EN
      if ($urandom_range(39) == 0) d = ~d;
`endif
      r = ($urandom_range(199) != 0);
      s = ($urandom_range(3) != 0);
      c = ($urandom_range(24) == 0);
      if ($urandom_range(9) < 7)
        v = d ? (m_prev + MOD - 1) % MOD : (m_prev + 1) % MOD;
      else
        v = $urandom_range(MOD - 1);
      drive(r, s, v, c, d);
      total++;
      if ({locked, err, err_cnt, expected, err_cnt2} !==
          {m_locked, m_err, 8'(m_cnt), 3'(m_exp), 2'(m_cnt_sat)}) begin
        bad++;
        $display("FAIL rand_%0d got locked=%0b err=%0b cnt=%0d exp=%0d sat=%0d want %0b/%0b/%0d/%0d/%0d",
                 i, locked, err, err_cnt, expected, err_cnt2, m_locked, m_err, m_cnt, m_exp, m_cnt_sat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_wrap();
    test_single_skip();
    test_lock_loss();
    test_saturation();
    test_gap();
    test_reset_mid();
`ifdef COUNT_SEQ_CHECKER_DOWN_EN
    test_down();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
